rou_unpack_buffer: RTL and testbench
====================================

ROU_UNPACK_BUFFER -- requirements
Module: rou_unpack_buffer

Interface
REQ-001 Ports, one per line: name  direction  width  meaning; the module SHALL provide exactly these.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- softreset  in  1  flush: clears buffer, transfer state and error.
- inline  in  128  aligned line; byte k = inline[8k+7:8k].
- in_offset  in  4  index of first valid byte in inline.
- in_bytes  in  5  valid byte count from in_offset, 0..16.
- in_valid  in  1  line offered.
- in_taken  out  1  line accepted this cycle when in_valid=1.
- xfer_start  in  1  start-transfer pulse.
- xfer_len  in  16  transfer length in bytes, sampled on xfer_start.
- reading  in  1  consumer pops this cycle.
- reading_bytes  in  5  bytes popped, 0..16.
- oline  out  128  packed bytes, oldest byte in [7:0].
- ovalids  out  5  valid bytes in oline, min(count,16).
- busy  out  1  transfer ACTIVE.
- xfer_done  out  1  one-cycle pulse at transfer end.
- oerr  out  1  sticky protocol error.
REQ-002 Parameters: none; buffer depth fixed at 64 bytes.

Function
REQ-003 Storage: 64 x 8-bit circular buffer; 7-bit wptr/rptr, index = ptr[5:0]; count = (wptr-rptr) mod 128, range 0..64.
REQ-004 eff_bytes = min(in_bytes, 16-in_offset); in_offset+in_bytes>16 sets oerr, extra bytes discarded.
REQ-005 in_taken = (count + eff_bytes <= 64), combinational from registered count; no credit from same-cycle pop.
REQ-006 On in_valid&&in_taken: buf[wptr+i] <= inline byte (in_offset+i) for i<eff_bytes; wptr += eff_bytes; eff_bytes=0 accepted, no change.
REQ-007 oline byte i = buf[rptr+i] when i<count, else 8'h00; ovalids = min(count,16); zero latency from registered state.
REQ-008 Pop legal when reading && reading_bytes<=ovalids && (state!=ACTIVE || reading_bytes<=remaining): rptr += reading_bytes.
REQ-009 Illegal pop: pointers unchanged, oerr set; reading_bytes=0 is a no-op, no error.
REQ-010 Simultaneous accepted push and legal pop: both applied same edge; new count = count+eff_bytes-reading_bytes.
REQ-011 Pointer wrap: 6-bit index wraps mod 64; 7-bit pointer wrap distinguishes full (count=64) from empty (count=0).
REQ-012 FSM states IDLE, ACTIVE, DONE; IDLE->ACTIVE on xfer_start with xfer_len>0, remaining<=xfer_len.
REQ-013 xfer_start with xfer_len=0 in IDLE: go DONE directly (xfer_done pulse next cycle, zero bytes).
REQ-014 ACTIVE: each legal pop subtracts reading_bytes from remaining; remaining reaching 0 -> DONE.
REQ-015 DONE lasts exactly one cycle, xfer_done=1, then IDLE; busy=1 only in ACTIVE.
REQ-016 xfer_start while ACTIVE or DONE: ignored, oerr set.
REQ-017 Pops in IDLE legal per REQ-008 but not counted; pushes accepted in every state.
REQ-018 softreset (priority over push, pop, xfer_start same cycle): wptr=rptr=0, state IDLE, remaining=0, oerr=0; next cycle in_taken reflects count 0.

Reset
REQ-019 rst_n=0 at a clock edge: wptr=rptr=0, state IDLE, remaining=0, oerr=0, all 64 buffer bytes 0.
REQ-020 During/after reset outputs: oline=0, ovalids=0, busy=0, xfer_done=0, oerr=0, in_taken=1.
REQ-021 Reset mid-transfer abandons transfer; no xfer_done pulse issued.

Verification
REQ-022 Offset strip: push in_offset=5, in_bytes=11, bytes 0x00..0x0F -> ovalids=11, oline[7:0]=0x05, oline[87:80]=0x0F, upper bytes 0.
REQ-023 Full: four pushes of 16 bytes -> count=64, in_taken=0 for in_bytes=1; same-cycle pop of 16 does not raise in_taken until next cycle.
REQ-024 Wrap: push/pop 16 bytes x 5 with incrementing data -> rptr index wraps past 63, oline data continuous, no oerr.
REQ-025 Transfer: xfer_len=20, pops 16 then 4 -> busy 1 for both, xfer_done one cycle after second pop; pop of 5 instead of 4 -> ignored, oerr=1.
REQ-026 Illegal input: in_offset=12, in_bytes=8 -> 4 bytes stored, oerr=1; softreset -> oerr=0, ovalids=0, state IDLE.

Source files
------------

// File: rtl/rou_unpack_buffer_if.sv
// Handshake and data bundle for the unpack buffer: line push side, transfer
// control, consumer pop side and status.
interface rou_unpack_buffer_if;
    logic         softreset;
    logic [127:0] inline;
    logic [3:0]   in_offset;
    logic [4:0]   in_bytes;
    logic         in_valid;
    logic         in_taken;
    logic         xfer_start;
    logic [15:0]  xfer_len;
    logic         reading;
    logic [4:0]   reading_bytes;
    logic [127:0] oline;
    logic [4:0]   ovalids;
    logic         busy;
    logic         xfer_done;
    logic         oerr;

    modport master (
        output softreset, inline, in_offset, in_bytes, in_valid,
               xfer_start, xfer_len, reading, reading_bytes,
        input  in_taken, oline, ovalids, busy, xfer_done, oerr
    );

    modport slave (
        input  softreset, inline, in_offset, in_bytes, in_valid,
               xfer_start, xfer_len, reading, reading_bytes,
        output in_taken, oline, ovalids, busy, xfer_done, oerr
    );
endinterface

// File: rtl/rou_unpack_buffer.sv
// 64-byte circular repacking buffer: strips offset/length from aligned lines,
// presents the oldest 16 bytes packed at bit 0, and tracks a byte-counted transfer.
module rou_unpack_buffer (
    input  logic              clk,
    input  logic              rst_n,
    rou_unpack_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

    state_e       state_q, state_d;
    logic [7:0]   buf_q [64];
    logic [6:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]  rem_q, rem_d;
    logic         oerr_q, oerr_d;

    logic [6:0]   count;
    logic [4:0]   room, eff, ovalids;
    logic [7:0]   fill;
    logic         push, pop, pop_ok, in_err;
    logic [7:0]   wbyte [16];
    logic [5:0]   widx  [16];

    assign count   = wptr_q - rptr_q;
    assign room    = 5'd16 - {1'b0, bus.in_offset};
    assign eff     = (bus.in_bytes < room) ? bus.in_bytes : room;
    assign fill    = {1'b0, count} + {3'b0, eff};
    assign in_err  = bus.in_valid && (({2'b0, bus.in_offset} + {1'b0, bus.in_bytes}) > 6'd16);
    // Credit comes only from registered count; a same-cycle pop frees space next cycle.
    assign bus.in_taken = (fill <= 8'd64);
    assign push    = bus.in_valid && bus.in_taken;
    assign ovalids = (count >= 7'd16) ? 5'd16 : count[4:0];
    assign pop_ok  = (bus.reading_bytes <= ovalids) &&
                     (state_q != ACTIVE || {11'b0, bus.reading_bytes} <= rem_q);
    assign pop     = bus.reading && (bus.reading_bytes != 5'd0) && pop_ok;

    assign bus.ovalids   = ovalids;
    assign bus.busy      = (state_q == ACTIVE);
    assign bus.xfer_done = (state_q == DONE);
    assign bus.oerr      = oerr_q;

    for (genvar i = 0; i < 16; i++) begin : g_lane
        logic [3:0] src;
        logic [5:0] ridx;
        assign src      = bus.in_offset + 4'(i);
        assign wbyte[i] = bus.inline[8*src +: 8];
        assign widx[i]  = wptr_q[5:0] + 6'(i);
        assign ridx     = rptr_q[5:0] + 6'(i);
        assign bus.oline[8*i +: 8] = (7'(i) < count) ? buf_q[ridx] : 8'h00;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        oerr_d  = oerr_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) wptr_d = wptr_q + {2'b0, eff};
        if (pop)  rptr_d = rptr_q + {2'b0, bus.reading_bytes};
        if (in_err || (bus.reading && !pop_ok)) oerr_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.xfer_start) begin
                    state_d = (bus.xfer_len == 16'd0) ? DONE : ACTIVE;
                    rem_d   = bus.xfer_len;
                end
            end
            ACTIVE: begin
                if (bus.xfer_start) oerr_d = 1'b1;
                if (pop) begin
                    rem_d = rem_q - {11'b0, bus.reading_bytes};
                    if (rem_d == 16'd0) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.xfer_start) oerr_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.softreset) begin
            state_d = IDLE;
            rem_d   = 16'd0;
            oerr_d  = 1'b0;
            wptr_d  = 7'd0;
            rptr_d  = 7'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= 16'd0;
            oerr_q  <= 1'b0;
            wptr_q  <= 7'd0;
            rptr_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            oerr_q  <= oerr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) buf_q[i] <= 8'h00;
        end else if (push && !bus.softreset) begin
            for (int i = 0; i < 16; i++)
                if (5'(i) < eff) buf_q[widx[i]] <= wbyte[i];
        end
    end
endmodule

// File: tb/tb_rou_unpack_buffer.sv
// Directed bench for rou_unpack_buffer: offset strip, full/credit, wrap,
// transfer sequencing, protocol errors, softreset and reset.
module tb_rou_unpack_buffer;
    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    rou_unpack_buffer_if bus ();

    rou_unpack_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int base, input int n);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 16; k++)
            if (k < n) m[8*k +: 8] = 8'(base + k);
        return m;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.softreset     = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_offset     = 4'd0;
        bus.in_bytes      = 5'd0;
        bus.xfer_start    = 1'b0;
        bus.xfer_len      = 16'd0;
        bus.reading       = 1'b0;
        bus.reading_bytes = 5'd0;
    endtask

    task automatic push(input int base, input int off, input int n);
        bus.inline    = mk(base, 16);
        bus.in_offset = 4'(off);
        bus.in_bytes  = 5'(n);
        bus.in_valid  = 1'b1;
        cyc();
        bus.in_valid  = 1'b0;
        #1;
    endtask

    task automatic pop(input int n);
        bus.reading       = 1'b1;
        bus.reading_bytes = 5'(n);
        cyc();
        bus.reading       = 1'b0;
        bus.reading_bytes = 5'd0;
        #1;
    endtask

    initial begin
        bus.inline = '0;
        quiet();
        rst_n = 1'b0;
        cyc(); cyc();
        chk("rst_oline",    bus.oline,     '0);
        chk("rst_ovalids",  bus.ovalids,   0);
        chk("rst_busy",     bus.busy,      0);
        chk("rst_done",     bus.xfer_done, 0);
        chk("rst_oerr",     bus.oerr,      0);
        chk("rst_in_taken", bus.in_taken,  1);
        rst_n = 1'b1;
        cyc();

        // Offset strip
        push(0, 5, 11);
        chk("strip_ovalids", bus.ovalids, 11);
        chk("strip_byte0",   bus.oline[7:0],   8'h05);
        chk("strip_byte10",  bus.oline[87:80], 8'h0F);
        chk("strip_line",    bus.oline, mk(5, 11));
        chk("strip_oerr",    bus.oerr, 0);
        pop(11);
        chk("strip_drain", bus.ovalids, 0);

        // Full buffer and credit timing
        for (int p = 0; p < 4; p++) push(p * 16, 0, 16);
        chk("full_ovalids", bus.ovalids, 16);
        chk("full_line",    bus.oline, mk(0, 16));
        bus.in_offset = 4'd0; bus.in_bytes = 5'd1; bus.in_valid = 1'b1;
        #1;
        chk("full_taken0", bus.in_taken, 0);
        bus.reading = 1'b1; bus.reading_bytes = 5'd16;
        #1;
        chk("full_taken_samecyc", bus.in_taken, 0);
        cyc();
        bus.reading = 1'b0; bus.reading_bytes = 5'd0;
        #1;
        chk("full_taken_next", bus.in_taken, 1);
        bus.in_valid = 1'b0;
        chk("full_after_pop", bus.oline, mk(16, 16));
        for (int p = 0; p < 3; p++) pop(16);
        chk("full_drain", bus.ovalids, 0);

        // Wrap of index and pointer
        for (int p = 0; p < 5; p++) begin
            push(8'h40 + p * 16, 0, 16);
            chk("wrap_line", bus.oline, mk(8'h40 + p * 16, 16));
            pop(16);
        end
        chk("wrap_empty", bus.ovalids, 0);
        chk("wrap_oerr",  bus.oerr, 0);

        // Simultaneous push and pop
        push(8'h90, 0, 16);
        bus.inline = mk(8'hA0, 16); bus.in_bytes = 5'd16; bus.in_valid = 1'b1;
        bus.reading = 1'b1; bus.reading_bytes = 5'd16;
        cyc();
        quiet();
        #1;
        chk("simul_ovalids", bus.ovalids, 16);
        chk("simul_line",    bus.oline, mk(8'hA0, 16));
        pop(16);

        // Transfer of 20 bytes: 16 + 4
        push(8'h10, 0, 16);
        push(8'h20, 0, 16);
        bus.xfer_start = 1'b1; bus.xfer_len = 16'd20;
        cyc();
        bus.xfer_start = 1'b0;
        chk("xfer_busy0", bus.busy, 1);
        pop(16);
        chk("xfer_busy1", bus.busy, 1);
        chk("xfer_nodone", bus.xfer_done, 0);
        pop(4);
        chk("xfer_done",   bus.xfer_done, 1);
        chk("xfer_busy2",  bus.busy, 0);
        chk("xfer_left",   bus.oline, mk(8'h24, 12));
        cyc();
        chk("xfer_done_off", bus.xfer_done, 0);
        chk("xfer_oerr",     bus.oerr, 0);

        // Overrun pop of 5 when 4 remain
        push(8'h30, 0, 16);
        bus.xfer_start = 1'b1; bus.xfer_len = 16'd20;
        cyc();
        bus.xfer_start = 1'b0;
        pop(16);
        pop(5);
        chk("over_oerr",    bus.oerr, 1);
        chk("over_ovalids", bus.ovalids, 12);
        chk("over_line",    bus.oline, mk(8'h34, 12));
        chk("over_busy",    bus.busy, 1);
        pop(4);
        chk("over_done",    bus.xfer_done, 1);
        chk("over_ovalids2", bus.ovalids, 8);

        // Illegal input line, then softreset
        bus.softreset = 1'b1;
        cyc();
        bus.softreset = 1'b0;
        chk("sr0_oerr", bus.oerr, 0);
        push(8'hA0, 12, 8);
        chk("ill_ovalids", bus.ovalids, 4);
        chk("ill_line",    bus.oline, mk(8'hAC, 4));
        chk("ill_oerr",    bus.oerr, 1);
        bus.softreset = 1'b1;
        cyc();
        bus.softreset = 1'b0;
        chk("sr_oerr",    bus.oerr, 0);
        chk("sr_ovalids", bus.ovalids, 0);
        chk("sr_busy",    bus.busy, 0);
        chk("sr_taken",   bus.in_taken, 1);

        // Zero-length transfer
        bus.xfer_start = 1'b1; bus.xfer_len = 16'd0;
        cyc();
        bus.xfer_start = 1'b0;
        chk("zlen_done", bus.xfer_done, 1);
        chk("zlen_busy", bus.busy, 0);
        cyc();
        chk("zlen_off", bus.xfer_done, 0);

        // Restart while active, then reset abandons transfer
        bus.xfer_start = 1'b1; bus.xfer_len = 16'd5;
        cyc();
        chk("rs_busy", bus.busy, 1);
        chk("rs_oerr0", bus.oerr, 0);
        cyc();
        bus.xfer_start = 1'b0;
        chk("rs_oerr1", bus.oerr, 1);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_oerr", bus.oerr, 0);
        rst_n = 1'b1;
        cyc();
        chk("mid_rst_done", bus.xfer_done, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
